rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter for the 32x32 register file's single write port. Two write-back sources (port A: ALU, port B: load unit) present writes through valid/ready handshakes; each port has a one-entry holding buffer. A registered round-robin grant drives `rd_addr`/`rd_w_data`/`reg_write` into the register file.

## Interface
- `DATA_W`, 32: write data width
- `ADDR_W`, 5: register address width

Ports:
- `clk` in 1: clock; all state updates on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `a_valid` in 1: port A write request
- `a_ready` out 1: port A can accept this cycle
- `a_addr` in ADDR_W: port A destination register
- `a_data` in DATA_W: port A write data
- `b_valid`, `b_ready`, `b_addr`, `b_data`: same as port A, for port B
- `rd_addr` out ADDR_W: register file write address
- `rd_w_data` out DATA_W: register file write data
- `reg_write` out 1: register file write enable
- `idle` out 1: both buffers empty and `reg_write` low

## Operation
- Handshake: transfer on the rising edge where `x_valid && x_ready`. `x_ready` is a function of registered state only, with no combinational path from any `valid`. Requesters must hold `addr`/`data` stable while `valid && !ready`.
- Buffer fill: a transfer with `addr != 0` loads buffer X (full=1). A transfer with `addr == 0` completes the handshake but is discarded: no buffer load and no register-file write.
- `x_ready = !buf_x_full || grant_x`. A granted buffer drains and refills on the same edge.
- Arbitration is combinational from buffer state and the pointer `rr` (0=A, 1=B):
  - Only A full: grant A.
  - Only B full: grant B.
  - Both full: grant the port selected by `rr`.
  - Neither full: no grant.
- On any grant, `rr` is set to point at the non-granted port.
- Output stage: on each edge, `reg_write <= grant_any`. On a grant, `rd_addr`/`rd_w_data` load from the granted buffer; otherwise they hold their value.
- Same-address writes from both ports are written in grant order, so the later-granted value persists.
- Reset (async, any time):
  - Buffers are emptied; pending writes are lost, not replayed.
  - `rr = 0`; `reg_write = 0`; `rd_addr = 0`; `rd_w_data = 0`.
  - Other outputs at reset: `a_ready = b_ready = 1`, `idle = 1`.

## Timing
- Uncontested latency: handshake at edge E0 → buffer full → granted, `reg_write` high after E1 → register file captures at E2.
- Throughput: one write per cycle total. A single port streams at one per cycle when uncontested. Under contention both ports alternate, each getting one write per 2 cycles.
- A port is never starved: a full buffer is granted within 2 cycles.
- Reset deassertion: the first handshake can occur on the first rising edge after `rst_n` rises.

## Configuration
- `RF_WB_FWD_EN`, when defined, adds:
  - Inputs `rs_addr`, `rt_addr` (ADDR_W).
  - Outputs `rs_fwd`, `rt_fwd` (1) and `rs_fwd_data`, `rt_fwd_data` (DATA_W).
- Forwarding behaviour:
  - `rs_fwd = reg_write && rd_addr == rs_addr && rs_addr != 0`, with `rs_fwd_data = rd_w_data`. `rt` is identical.
  - Adds outputs `rs_pend`/`rt_pend`, high when a full buffer holds the matching nonzero address. The consumer stalls on pend.
- Not defined: these ports are absent and behaviour is otherwise identical.

## Test plan
- Reset, then A writes (r3, 0xDEADBEEF) at E0: `reg_write=1`, `rd_addr=3`, data 0xDEADBEEF after E1; `a_ready` stays high.
- A and B valid every cycle (A: r1..r4, B: r5..r8): writes alternate A,B,A,B starting with A, all 8 written, none lost or duplicated.
- A writes r0 = 0x1234: handshake completes, `reg_write` stays 0, `idle` stays 1.
- A and B both write r7 (0x11, 0x22) in the same cycle with `rr=0`: r7 ends at 0x22.
- Both buffers full, assert `rst_n=0` mid-cycle: `reg_write`, `rd_addr`, `rd_w_data` go 0 immediately; after release no stale write appears.
- `RF_WB_FWD_EN`, A writes r9 = 0x55 with `rs_addr=9`: `rs_pend=1` while buffered, then `rs_fwd=1` with 0x55 during the `reg_write` cycle.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin write-back arbiter for the register file write port (optional forwarding via RF_WB_FWD_EN)
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
`ifdef RF_WB_FWD_EN
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_fwd,
  output logic              rt_fwd,
  output logic [DATA_W-1:0] rs_fwd_data,
  output logic [DATA_W-1:0] rt_fwd_data,
  output logic              rs_pend,
  output logic              rt_pend,
`endif
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_w_data,
  output logic              reg_write,
  output logic              idle
);
  logic              a_full, b_full, rr, grant_a, grant_b;
  logic [ADDR_W-1:0] a_buf_addr, b_buf_addr;
  logic [DATA_W-1:0] a_buf_data, b_buf_data;
  // grant from buffer occupancy; rr breaks ties (0 = A, 1 = B)
  always_comb begin
    grant_a = a_full && (!b_full || !rr);
    grant_b = b_full && (!a_full || rr);
  end
  assign a_ready = !a_full || grant_a;
  assign b_ready = !b_full || grant_b;
  assign idle    = !a_full && !b_full && !reg_write;
  // port A holding buffer: r0 writes complete the handshake but never fill it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_full     <= 1'b0;
      a_buf_addr <= '0;
      a_buf_data <= '0;
    end else if (a_valid && a_ready) begin
      a_full     <= a_addr != '0;
      a_buf_addr <= a_addr;
      a_buf_data <= a_data;
    end else if (grant_a) a_full <= 1'b0;
  // port B holding buffer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      b_full     <= 1'b0;
      b_buf_addr <= '0;
      b_buf_data <= '0;
    end else if (b_valid && b_ready) begin
      b_full     <= b_addr != '0;
      b_buf_addr <= b_addr;
      b_buf_data <= b_data;
    end else if (grant_b) b_full <= 1'b0;
  // registered output stage and round-robin pointer update
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      reg_write <= 1'b0;
      rd_addr   <= '0;
      rd_w_data <= '0;
      rr        <= 1'b0;
    end else begin
      reg_write <= grant_a || grant_b;
      if (grant_a) begin
        rd_addr   <= a_buf_addr;
        rd_w_data <= a_buf_data;
        rr        <= 1'b1;
      end else if (grant_b) begin
        rd_addr   <= b_buf_addr;
        rd_w_data <= b_buf_data;
        rr        <= 1'b0;
      end
    end
`ifdef RF_WB_FWD_EN
  assign rs_fwd      = reg_write && rd_addr == rs_addr && rs_addr != '0;
  assign rt_fwd      = reg_write && rd_addr == rt_addr && rt_addr != '0;
  assign rs_fwd_data = rd_w_data;
  assign rt_fwd_data = rd_w_data;
  assign rs_pend     = rs_addr != '0 && ((a_full && a_buf_addr == rs_addr) || (b_full && b_buf_addr == rs_addr));
  assign rt_pend     = rt_addr != '0 && ((a_full && a_buf_addr == rt_addr) || (b_full && b_buf_addr == rt_addr));
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed bench with a transaction-level model of the write-back arbiter
module tb_rf_wb_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0, a_ready, b_ready, reg_write, idle;
  logic [4:0]  a_addr = '0, b_addr = '0, rd_addr;
  logic [31:0] a_data = '0, b_data = '0, rd_w_data;
`ifdef RF_WB_FWD_EN
  logic [4:0]  rs_addr = '0, rt_addr = '0;
  logic        rs_fwd, rt_fwd, rs_pend, rt_pend;
  logic [31:0] rs_fwd_data, rt_fwd_data;
`endif
  int vectors = 0, fails = 0;

  rf_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
`ifdef RF_WB_FWD_EN
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_fwd(rs_fwd), .rt_fwd(rt_fwd),
    .rs_fwd_data(rs_fwd_data), .rt_fwd_data(rt_fwd_data), .rs_pend(rs_pend), .rt_pend(rt_pend),
`endif
    .rd_addr(rd_addr), .rd_w_data(rd_w_data), .reg_write(reg_write), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: each port holds at most one pending write; contested cycles go to the port not served last
  logic        ma_full = 0, mb_full = 0, m_b_turn = 0, m_we = 0;
  logic [4:0]  ma_addr, mb_addr, m_addr = '0;
  logic [31:0] ma_data, mb_data, m_data = '0;
  wire m_wa = ma_full && !(mb_full && m_b_turn);
  wire m_wb = mb_full && !m_wa;
  wire m_a_rdy = !ma_full || m_wa;
  wire m_b_rdy = !mb_full || m_wb;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ma_full <= 0; mb_full <= 0; m_b_turn <= 0; m_we <= 0; m_addr <= '0; m_data <= '0;
    end else begin
      m_we <= m_wa || m_wb;
      if (m_wa) begin m_addr <= ma_addr; m_data <= ma_data; m_b_turn <= 1; end
      if (m_wb) begin m_addr <= mb_addr; m_data <= mb_data; m_b_turn <= 0; end
      if (a_valid && m_a_rdy) begin ma_full <= a_addr != 0; ma_addr <= a_addr; ma_data <= a_data; end
      else if (m_wa) ma_full <= 0;
      if (b_valid && m_b_rdy) begin mb_full <= b_addr != 0; mb_addr <= b_addr; mb_data <= b_data; end
      else if (m_wb) mb_full <= 0;
    end

  bit run_cmp = 0;
  always @(negedge clk)
    if (run_cmp) begin
      chk("reg_write", reg_write, m_we);
      if (m_we) chk("rd_addr", rd_addr, m_addr);
      if (m_we) chk("rd_w_data", rd_w_data, m_data);
      chk("a_ready", a_ready, m_a_rdy);
      chk("b_ready", b_ready, m_b_rdy);
      chk("idle", idle, !ma_full && !mb_full && !m_we);
    end

  // register file as seen by the DUT's write port, plus write-order log
  logic [31:0] rf [32];
  logic [4:0]  wlog [$];
  always @(posedge clk)
    if (rst_n && reg_write) begin
      rf[rd_addr] <= rd_w_data;
      wlog.push_back(rd_addr);
    end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; a_valid = 0; b_valid = 0;
    @(negedge clk);
    rst_n = 1;
    wlog.delete();
  endtask

  task automatic drain(input int n);
    a_valid = 0; b_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  logic [4:0] exp_ord [8] = '{5'd1, 5'd5, 5'd2, 5'd6, 5'd3, 5'd7, 5'd4, 5'd8};
  int ia, ib;
  bit xa, xb;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_w_data", rd_w_data, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_idle", idle, 1);
    rst_n = 1;
    run_cmp = 1;
    // single uncontested write
    a_valid = 1; a_addr = 3; a_data = 32'hDEADBEEF;
    @(negedge clk);
    a_valid = 0;
    chk("t1_a_ready_e0", a_ready, 1);
    chk("t1_we_e0", reg_write, 0);
    @(negedge clk);
    chk("t1_we_e1", reg_write, 1);
    chk("t1_addr_e1", rd_addr, 3);
    chk("t1_data_e1", rd_w_data, 32'hDEADBEEF);
    chk("t1_a_ready_e1", a_ready, 1);
    drain(2);
    // r0 write is accepted but discarded
    a_valid = 1; a_addr = 0; a_data = 32'h1234;
    @(negedge clk);
    a_valid = 0;
    chk("r0_idle_e0", idle, 1);
    chk("r0_we_e0", reg_write, 0);
    @(negedge clk);
    chk("r0_we_e1", reg_write, 0);
    chk("r0_idle_e1", idle, 1);
    // both ports streaming
    do_reset();
    ia = 0; ib = 0;
    for (int c = 0; c < 30 && (ia < 4 || ib < 4); c++) begin
      a_valid = ia < 4; a_addr = 5'(1 + ia); a_data = 32'hA0 + ia;
      b_valid = ib < 4; b_addr = 5'(5 + ib); b_data = 32'hB0 + ib;
      xa = a_valid && a_ready; xb = b_valid && b_ready;
      @(negedge clk);
      if (xa) ia++;
      if (xb) ib++;
    end
    chk("stream_a_done", ia, 4);
    chk("stream_b_done", ib, 4);
    drain(4);
    chk("stream_len", wlog.size(), 8);
    for (int i = 0; i < 8; i++) if (i < wlog.size()) chk($sformatf("stream_ord%0d", i), wlog[i], exp_ord[i]);
    chk("stream_r1", rf[1], 32'hA0);
    chk("stream_r8", rf[8], 32'hB3);
    // same address from both ports: B written last
    do_reset();
    a_valid = 1; a_addr = 7; a_data = 32'h11;
    b_valid = 1; b_addr = 7; b_data = 32'h22;
    @(negedge clk);
    drain(4);
    chk("same_len", wlog.size(), 2);
    chk("same_r7", rf[7], 32'h22);
    // reset while both buffers are full
    do_reset();
    a_valid = 1; a_addr = 10; a_data = 32'hAAAA;
    b_valid = 1; b_addr = 11; b_data = 32'hBBBB;
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    chk("mid_we_before", reg_write, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_we", reg_write, 0);
    chk("mid_rd_addr", rd_addr, 0);
    chk("mid_rd_w_data", rd_w_data, 0);
    chk("mid_idle", idle, 1);
    @(negedge clk);
    rst_n = 1;
    wlog.delete();
    repeat (4) @(negedge clk);
    chk("mid_no_stale", wlog.size(), 0);
`ifdef RF_WB_FWD_EN
    rs_addr = 9;
    a_valid = 1; a_addr = 9; a_data = 32'h55;
    @(negedge clk);
    a_valid = 0;
    chk("fwd_pend", rs_pend, 1);
    chk("fwd_nofwd", rs_fwd, 0);
    @(negedge clk);
    chk("fwd_fwd", rs_fwd, 1);
    chk("fwd_data", rs_fwd_data, 32'h55);
    chk("fwd_pend_clr", rs_pend, 0);
    drain(2);
`endif
    run_cmp = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
